// File: rtl/dvi_timing_gen.sv
// Raster timing generator for a DVI transmitter: walks an (h,v) position
// across the full frame and registers de, syncs, control pairs and coordinates.
module dvi_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic [1:0]    ctrl_b,
    output logic [1:0]    ctrl_gr,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic [XW-1:0] h_q, h_d, x_q, x_d;
    logic [YW-1:0] v_q, v_d, y_q, y_d;
    logic          de_q, de_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
        h_d           = h_q;
        v_d           = v_q;
        x_d           = x_q;
        y_d           = y_q;
        de_d          = de_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;

        if (en) begin
            h_d = (h_q == H_LAST) ? '0 : h_q + XW'(1);
            if (h_q == H_LAST) begin
                v_d = (v_q == V_LAST) ? '0 : v_q + YW'(1);
            end

            // Outputs describe the position held before this edge.
            de_d          = (h_q < H_ACT) && (v_q < V_ACT);
            hsync_d       = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
            vsync_d       = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
            x_d           = h_q;
            y_d           = v_q;
            line_start_d  = (h_q == '0);
            frame_start_d = (h_q == '0) && (v_q == '0);
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            h_q           <= '0;
            v_q           <= '0;
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign ctrl_b      = {vsync_q, hsync_q};
    assign ctrl_gr     = 2'b00;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Directed bench for dvi_timing_gen: default 640x480 instance plus a tiny
// inverted-polarity instance that makes whole-frame checks affordable.
module tb_dvi_timing_gen;

    int checks = 0;
    int errors = 0;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default-timing instance
    logic       d_rstn, d_en;
    logic       d_de, d_hsync, d_vsync, d_ls, d_fs;
    logic [1:0] d_ctrl_b, d_ctrl_gr;
    logic [9:0] d_x, d_y;
    logic [28:0] d_vec;
    assign d_vec = {d_de, d_hsync, d_vsync, d_ctrl_b, d_ctrl_gr, d_ls, d_fs, d_x, d_y};

    dvi_timing_gen u_dut_d (
        .clk(clk), .rstn(d_rstn), .en(d_en), .de(d_de), .hsync(d_hsync), .vsync(d_vsync),
        .ctrl_b(d_ctrl_b), .ctrl_gr(d_ctrl_gr), .x(d_x), .y(d_y),
        .line_start(d_ls), .frame_start(d_fs)
    );

    // Tiny instance: H 8/2/3/2 (total 15), V 4/1/2/1 (total 8), active-high syncs
    logic       s_rstn, s_en;
    logic       s_de, s_hsync, s_vsync, s_ls, s_fs;
    logic [1:0] s_ctrl_b, s_ctrl_gr;
    logic [3:0] s_x, s_y;
    logic [16:0] s_vec;
    assign s_vec = {s_de, s_hsync, s_vsync, s_ctrl_b, s_ctrl_gr, s_ls, s_fs, s_x, s_y};

    dvi_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .XW(4), .YW(4)
    ) u_dut_s (
        .clk(clk), .rstn(s_rstn), .en(s_en), .de(s_de), .hsync(s_hsync), .vsync(s_vsync),
        .ctrl_b(s_ctrl_b), .ctrl_gr(s_ctrl_gr), .x(s_x), .y(s_y),
        .line_start(s_ls), .frame_start(s_fs)
    );

    localparam logic [28:0] D_RST = {1'b0, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 10'd0, 10'd0};
    localparam logic [16:0] S_RST = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0};

    int d_ex, d_ey, s_ex, s_ey;

    function automatic logic [28:0] d_model(int ex, int ey);
        logic hs, vs;
        hs = !(ex >= 656 && ex < 752);
        vs = !(ey >= 490 && ey < 492);
        return {(ex < 640 && ey < 480), hs, vs, vs, hs, 2'b00, (ex == 0), (ex == 0 && ey == 0),
                10'(ex), 10'(ey)};
    endfunction

    function automatic logic [16:0] s_model(int ex, int ey);
        logic hs, vs;
        hs = (ex >= 10 && ex < 13);
        vs = (ey >= 5 && ey < 7);
        return {(ex < 8 && ey < 4), hs, vs, vs, hs, 2'b00, (ex == 0), (ex == 0 && ey == 0),
                4'(ex), 4'(ey)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic d_adv;
        d_ex++;
        if (d_ex == 800) begin
            d_ex = 0;
            d_ey = (d_ey + 1) % 525;
        end
    endtask

    task automatic s_adv;
        s_ex++;
        if (s_ex == 15) begin
            s_ex = 0;
            s_ey = (s_ey + 1) % 8;
        end
    endtask

    task automatic test_reset;
        d_rstn = 1'b0;
        d_en   = 1'b1;
        tick;
        tick;
        checks++;
        if (d_vec !== D_RST) begin
            errors++;
            $display("FAIL reset_state got %h want %h", d_vec, D_RST);
        end
        d_rstn = 1'b1;
        tick;
        d_ex = 0;
        d_ey = 0;
        checks++;
        if (d_vec !== d_model(0, 0) || d_de !== 1'b1 || d_fs !== 1'b1 || d_ls !== 1'b1) begin
            errors++;
            $display("FAIL first_pixel got %h want %h", d_vec, d_model(0, 0));
        end
    endtask

    task automatic test_line_timing;
        int de_cnt, hs_cnt, ls_cnt;
        de_cnt = 0; hs_cnt = 0; ls_cnt = 0;
        for (int i = 0; i < 2400; i++) begin
            checks++;
            if (d_vec !== d_model(d_ex, d_ey)) begin
                errors++;
                $display("FAIL line_px (%0d,%0d) got %h want %h", d_ex, d_ey, d_vec, d_model(d_ex, d_ey));
            end
            de_cnt += int'(d_de);
            hs_cnt += int'(!d_hsync);
            ls_cnt += int'(d_ls);
            d_adv;
            tick;
        end
        checks++;
        if (de_cnt != 1920) begin
            errors++;
            $display("FAIL de_per_3_lines got %0d want 1920", de_cnt);
        end
        checks++;
        if (hs_cnt != 288) begin
            errors++;
            $display("FAIL hsync_low_per_3_lines got %0d want 288", hs_cnt);
        end
        checks++;
        if (ls_cnt != 3) begin
            errors++;
            $display("FAIL line_start_per_3_lines got %0d want 3", ls_cnt);
        end
    endtask

    task automatic test_line_wrap;
        for (int i = 0; i < 20000 && !(d_ex == 799 && d_ey == 10); i++) begin
            checks++;
            if (d_vec !== d_model(d_ex, d_ey)) begin
                errors++;
                $display("FAIL run_px (%0d,%0d) got %h want %h", d_ex, d_ey, d_vec, d_model(d_ex, d_ey));
            end
            d_adv;
            tick;
        end
        checks++;
        if (d_x !== 10'd799 || d_y !== 10'd10) begin
            errors++;
            $display("FAIL reach_799_10 got (%0d,%0d) want (799,10)", d_x, d_y);
        end
        tick;
        d_adv;
        checks++;
        if (d_x !== 10'd0 || d_y !== 10'd11 || d_ls !== 1'b1 || d_fs !== 1'b0 || d_de !== 1'b1) begin
            errors++;
            $display("FAIL line_wrap got (%0d,%0d) ls=%b fs=%b de=%b want (0,11) ls=1 fs=0 de=1",
                     d_x, d_y, d_ls, d_fs, d_de);
        end
    endtask

    task automatic test_en_toggle;
        for (int i = 0; i < 900; i++) begin
            d_en = 1'b1;
            tick;
            d_adv;
            checks++;
            if (d_vec !== d_model(d_ex, d_ey)) begin
                errors++;
                $display("FAIL en_step (%0d,%0d) got %h want %h", d_ex, d_ey, d_vec, d_model(d_ex, d_ey));
            end
            d_en = 1'b0;
            tick;
            checks++;
            if (d_vec !== d_model(d_ex, d_ey)) begin
                errors++;
                $display("FAIL en_hold (%0d,%0d) got %h want %h", d_ex, d_ey, d_vec, d_model(d_ex, d_ey));
            end
        end
        d_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 2000 && !(d_ex == 300 && d_ey == 12); i++) begin
            d_adv;
            tick;
        end
        checks++;
        if (d_x !== 10'd300 || d_y !== 10'd12) begin
            errors++;
            $display("FAIL reach_300_12 got (%0d,%0d) want (300,12)", d_x, d_y);
        end
        d_rstn = 1'b0;
        tick;
        checks++;
        if (d_vec !== D_RST) begin
            errors++;
            $display("FAIL mid_reset got %h want %h", d_vec, D_RST);
        end
        d_rstn = 1'b1;
        tick;
        d_ex = 0;
        d_ey = 0;
        checks++;
        if (d_vec !== d_model(0, 0) || d_fs !== 1'b1) begin
            errors++;
            $display("FAIL after_mid_reset got %h want %h", d_vec, d_model(0, 0));
        end
    endtask

    task automatic test_small_reset;
        s_rstn = 1'b0;
        s_en   = 1'b0;
        tick;
        checks++;
        if (s_vec !== S_RST) begin
            errors++;
            $display("FAIL pol_reset got %h want %h", s_vec, S_RST);
        end
        s_rstn = 1'b1;
        s_en   = 1'b1;
        tick;
        s_ex = 0;
        s_ey = 0;
        checks++;
        if (s_vec !== s_model(0, 0) || s_fs !== 1'b1 || s_ctrl_b !== 2'b00) begin
            errors++;
            $display("FAIL pol_first got %h want %h", s_vec, s_model(0, 0));
        end
    endtask

    task automatic test_small_frame;
        int fs_cnt, de_cnt, vs_cnt, hs_cnt;
        fs_cnt = 0; de_cnt = 0; vs_cnt = 0; hs_cnt = 0;
        for (int i = 0; i < 240; i++) begin
            checks++;
            if (s_vec !== s_model(s_ex, s_ey)) begin
                errors++;
                $display("FAIL frame_px (%0d,%0d) got %h want %h", s_ex, s_ey, s_vec, s_model(s_ex, s_ey));
            end
            fs_cnt += int'(s_fs);
            de_cnt += int'(s_de);
            vs_cnt += int'(s_vsync);
            hs_cnt += int'(s_hsync);
            if (s_ex == 14 && s_ey == 7) begin
                tick;
                s_adv;
                checks++;
                if (s_x !== 4'd0 || s_y !== 4'd0 || s_fs !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_wrap got (%0d,%0d) fs=%b want (0,0) fs=1", s_x, s_y, s_fs);
                end
            end else begin
                s_adv;
                tick;
            end
        end
        checks++;
        if (fs_cnt != 2 || de_cnt != 64 || vs_cnt != 60 || hs_cnt != 48) begin
            errors++;
            $display("FAIL frame_counts got fs=%0d de=%0d vs=%0d hs=%0d want fs=2 de=64 vs=60 hs=48",
                     fs_cnt, de_cnt, vs_cnt, hs_cnt);
        end
    endtask

    task automatic test_small_en_toggle;
        int rises;
        logic prev;
        rises = 0;
        prev  = s_fs;
        for (int i = 0; i < 240; i++) begin
            s_en = 1'b1;
            tick;
            s_adv;
            if (s_fs && !prev) rises++;
            prev = s_fs;
            s_en = 1'b0;
            tick;
            checks++;
            if (s_vec !== s_model(s_ex, s_ey)) begin
                errors++;
                $display("FAIL pol_en_hold (%0d,%0d) got %h want %h", s_ex, s_ey, s_vec, s_model(s_ex, s_ey));
            end
            if (s_fs && !prev) rises++;
            prev = s_fs;
        end
        s_en = 1'b1;
        checks++;
        if (rises != 2) begin
            errors++;
            $display("FAIL pol_en_frame_start got %0d want 2", rises);
        end
    endtask

    task automatic test_small_reset_mid;
        for (int i = 0; i < 200 && !(s_ex == 5 && s_ey == 2); i++) begin
            s_adv;
            tick;
        end
        s_rstn = 1'b0;
        tick;
        checks++;
        if (s_vec !== S_RST) begin
            errors++;
            $display("FAIL pol_mid_reset got %h want %h", s_vec, S_RST);
        end
        s_rstn = 1'b1;
        tick;
        checks++;
        if (s_vec !== s_model(0, 0)) begin
            errors++;
            $display("FAIL pol_after_reset got %h want %h", s_vec, s_model(0, 0));
        end
    endtask

    initial begin
        d_rstn = 1'b0;
        d_en   = 1'b0;
        s_rstn = 1'b0;
        s_en   = 1'b0;
        test_reset;
        test_line_timing;
        test_line_wrap;
        test_en_toggle;
        test_reset_mid;
        test_small_reset;
        test_small_frame;
        test_small_en_toggle;
        test_small_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dvi_timing_gen.md
Name: dvi_timing_gen

Overview:
- Generates raster timing that sequences the three TMDS encoder lanes: data enable, hsync/vsync, the blue-lane control pair, and pixel coordinates.
- Sits between the pixel-clock domain and the per-lane encoders.
- The pixel source uses x/y to produce RGB; the encoders consume de and ctrl in the same cycle.
- Default timing is 640x480@60 (25.175 MHz pixel clock).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
XW, 10, width of x counter/output
YW, 10, width of y counter/output

Ports:
clk  in  1  pixel clock
rstn  in  1  reset, synchronous, active-low
en  in  1  pixel-clock enable; when low, all state and outputs hold
de  out  1  data enable to all encoder lanes; high in the visible region
hsync  out  1  horizontal sync at HS_POL level when asserted
vsync  out  1  vertical sync at VS_POL level when asserted
ctrl_b  out  2  blue-lane control pair {vsync, hsync}, polarity-applied
ctrl_gr  out  2  green/red-lane control pair, constant 2'b00
x  out  XW  horizontal position of the current output pixel
y  out  YW  vertical position of the current output pixel
line_start  out  1  one-cycle pulse, coincident with h position 0 of every line
frame_start  out  1  one-cycle pulse, coincident with position (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must fit in XW/YW bits.
- Internal counters: h in 0..H_TOTAL-1 and v in 0..V_TOTAL-1.
- On each clk edge with en=1:
  - All outputs are registered from a decode of the current (h,v).
  - h advances. At H_TOTAL-1, h wraps to 0 and v advances.
  - v wraps to 0 after V_TOTAL-1 when h also wraps.
- Latency: outputs describe the position the counters held before the edge. The first en edge after reset release presents (0,0) with de=1, frame_start=1, line_start=1.
- Decode rules:
  - de = (h<H_ACTIVE) && (v<V_ACTIVE).
  - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, on every line including vertical blanking.
  - vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for all h of those lines (transitions at h=0).
  - Output levels: hsync = asserted ? HS_POL : ~HS_POL. vsync uses the same rule with VS_POL.
- x = h and y = v, valid whether or not de is high. The pixel source gates its use of x/y by de.
- ctrl_b = {vsync, hsync} as driven on the pins. ctrl_gr = 2'b00 always.
- line_start = (h==0). frame_start = (h==0 && v==0).
- en=0: counters and all outputs hold their values; no pulse is repeated or extended. A pulse held high through an en=0 gap is permitted.
- Reset (rstn=0 at a clk edge, en ignored):
  - h=0, v=0, de=0, x=0, y=0, line_start=0, frame_start=0.
  - hsync=~HS_POL, vsync=~VS_POL, ctrl_b = {~VS_POL, ~HS_POL}, ctrl_gr=0.
  - Reset mid-frame aborts the frame immediately. There is no partial-line flush.
- No combinational path from any input to any output.

Test Plan:
- Reset then en=1 held -> first edge: de=1, x=0, y=0, frame_start=1, line_start=1, hsync=1, vsync=1 (defaults, active-low idle high).
- Line timing, defaults -> de high for exactly 640 consecutive cycles per line. hsync=0 for output x=656..751 (96 cycles). Line period 800 cycles; line_start period 800.
- Frame timing -> vsync=0 for y=490..491 (1600 cycles, edges at x=0). frame_start period 420000 cycles. 480 lines with de bursts per frame. No de for y>=480.
- Wrap boundaries -> output (799,524) is followed by (0,0) with frame_start=1. Output (799,10) is followed by (0,11).
- en toggling (en low every other cycle) -> sequence of (x,y,de,hsync,vsync) identical to the continuous run, each value held 2 cycles. frame_start still appears once per frame.
- Reset mid-line at (x=300,y=200) -> outputs go to reset values on that edge. The next en edge presents (0,0) with frame_start=1. Repeat with HS_POL=1, VS_POL=1 -> idle sync levels 0, ctrl_b idle = 2'b00.
